// File: rtl/pad_bus_ctrl_pkg.sv
// pad_bus_ctrl_pkg: shared state encoding, counter sizing and parameter checks for the pad bus controller.
package pad_bus_ctrl_pkg;
    typedef enum logic [1:0] {RX, TURN_OUT, DRIVE, TURN_IN} state_t;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic bit params_ok(input int turn, input int hold, input int filter);
        return turn >= 1 && hold >= 1 && filter >= 1;
    endfunction
endpackage

// File: rtl/pad_bus_if.sv
// pad_bus_if: core handshake plus pad A/EN/Y pins of the bidirectional pad bus.
interface pad_bus_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             dir_out;
    logic [WIDTH-1:0] pad_a;
    logic [WIDTH-1:0] pad_en;
    logic [WIDTH-1:0] pad_y;
    modport slave (input tx_data, tx_valid, pad_y, output tx_ready, rx_data, rx_valid, dir_out, pad_a, pad_en);
    modport master (output tx_data, tx_valid, pad_y, input tx_ready, rx_data, rx_valid, dir_out, pad_a, pad_en);
endinterface

// File: rtl/pad_bus_ctrl_in_filter.sv
// pad_in_filter: synchronises pad Y and accepts a new word only after it has been stable for FILTER+1 samples.
module pad_in_filter
    import pad_bus_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int FILTER = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] pad_y,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid
);
    localparam int FW = cnt_w(FILTER);
    logic [WIDTH-1:0] s1, s2, cand;
    logic [FW-1:0]    flt_cnt;
    // While disabled cand tracks s2, so the bus's own echo never builds up a count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            cand     <= '0;
            flt_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            s1       <= pad_y;
            s2       <= s1;
            rx_valid <= 1'b0;
            if (!en || s2 != cand) begin
                cand    <= s2;
                flt_cnt <= '0;
            end else if (cand != rx_data) begin
                if (flt_cnt == FW'(FILTER - 1)) begin
                    rx_data  <= cand;
                    rx_valid <= 1'b1;
                    flt_cnt  <= '0;
                end else begin
                    flt_cnt <= flt_cnt + FW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/pad_bus_ctrl.sv
// pad_bus_ctrl: owns pad bus direction with turnaround dead cycles, drives outbound words, filters inbound words.
module pad_bus_ctrl
    import pad_bus_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int TURN   = 2,
    parameter int HOLD   = 1,
    parameter int FILTER = 3
) (
    input logic     clk,
    input logic     rst,
    pad_bus_if.slave bus
);
    localparam int TW = cnt_w(TURN);
    localparam int HW = cnt_w(HOLD);
    if (!params_ok(TURN, HOLD, FILTER)) begin : g_bad_params
        $error("pad_bus_ctrl: TURN, HOLD and FILTER must all be >= 1");
    end
    state_t           state, state_n;
    logic [TW-1:0]    turn_cnt, turn_n;
    logic [HW-1:0]    hold_cnt, hold_n;
    logic [WIDTH-1:0] pad_a_q, pa_n, en_q;
    logic             dir_q, ready;
    assign ready      = !rst && (state == RX || (state == DRIVE && hold_cnt == '0));
    assign bus.tx_ready = ready;
    assign bus.pad_a    = pad_a_q;
    assign bus.pad_en   = en_q;
    assign bus.dir_out  = dir_q;
    always_comb begin
        state_n = state;
        turn_n  = turn_cnt;
        hold_n  = hold_cnt;
        pa_n    = pad_a_q;
        case (state)
            RX: if (bus.tx_valid && ready) begin
                pa_n    = bus.tx_data;
                turn_n  = TW'(TURN - 1);
                state_n = TURN_OUT;
            end
            TURN_OUT: if (turn_cnt == '0) begin
                hold_n  = HW'(HOLD - 1);
                state_n = DRIVE;
            end else begin
                turn_n = turn_cnt - TW'(1);
            end
            DRIVE: if (hold_cnt != '0) begin
                hold_n = hold_cnt - HW'(1);
            end else if (bus.tx_valid) begin
                pa_n   = bus.tx_data;
                hold_n = HW'(HOLD - 1);
            end else begin
                turn_n  = TW'(TURN - 1);
                state_n = TURN_IN;
            end
            TURN_IN: if (turn_cnt == '0) state_n = RX;
                     else turn_n = turn_cnt - TW'(1);
            default: state_n = RX;
        endcase
    end
    // Enable and direction are registered from next state so the pads see glitch-free levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RX;
            turn_cnt <= '0;
            hold_cnt <= '0;
            pad_a_q  <= '0;
            en_q     <= '1;
            dir_q    <= 1'b0;
        end else begin
            state    <= state_n;
            turn_cnt <= turn_n;
            hold_cnt <= hold_n;
            pad_a_q  <= pa_n;
            en_q     <= {WIDTH{state_n != DRIVE}};
            dir_q    <= state_n == TURN_OUT || state_n == DRIVE;
        end
    end
    pad_in_filter #(.WIDTH(WIDTH), .FILTER(FILTER)) u_in_filter (
        .clk      (clk),
        .rst      (rst),
        .en       (state == RX),
        .pad_y    (bus.pad_y),
        .rx_data  (bus.rx_data),
        .rx_valid (bus.rx_valid)
    );
endmodule

// File: tb/tb_pad_bus_ctrl.sv
// tb_pad_bus_ctrl: directed and random stimulus against a run-length behavioural model of the pad bus controller.
module tb_pad_bus_ctrl;
    localparam int W = 8, TURN = 2, HOLD = 1, FILTER = 3;
    localparam int M_RX = 0, M_OUT = 1, M_DRV = 2, M_IN = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    pad_bus_if #(.WIDTH(W)) bus ();
    pad_bus_ctrl #(.WIDTH(W), .TURN(TURN), .HOLD(HOLD), .FILTER(FILTER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    int n_chk = 0, n_fail = 0, pulses = 0;
    int mode, left, run;
    logic [W-1:0] m_pa, m_rx, y_d1, y_d2, prev;
    bit m_valid, m_acc;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic void m_reset();
        mode = M_RX; left = 0; run = 1;
        m_pa = '0; m_rx = '0; y_d1 = '0; y_d2 = '0; prev = '0;
        m_valid = 1'b0; m_acc = 1'b0;
    endfunction
    function automatic bit m_ready();
        return mode == M_RX || (mode == M_DRV && left == 0);
    endfunction
    // Inbound rule: a word seen in s2 for FILTER+1 consecutive enabled samples is delivered once.
    function automatic void model_edge();
        bit en = (mode == M_RX);
        logic [W-1:0] obs = y_d2;
        m_acc = bus.tx_valid && m_ready();
        run = (!en || obs != prev) ? 1 : run + 1;
        prev = obs;
        m_valid = en && run == FILTER + 1 && obs != m_rx;
        if (m_valid) m_rx = obs;
        y_d2 = y_d1;
        y_d1 = bus.pad_y;
        case (mode)
            M_RX: if (m_acc) begin m_pa = bus.tx_data; mode = M_OUT; left = TURN - 1; end
            M_OUT: if (left == 0) begin mode = M_DRV; left = HOLD - 1; end else left--;
            M_DRV: if (left > 0) left--;
                   else if (bus.tx_valid) begin m_pa = bus.tx_data; left = HOLD - 1; end
                   else begin mode = M_IN; left = TURN - 1; end
            default: if (left == 0) mode = M_RX; else left--;
        endcase
    endfunction
    task automatic check_all();
        logic [W-1:0] en_exp = (mode == M_DRV) ? '0 : '1;
        chk("pad_en", bus.pad_en, en_exp);
        chk("pad_a", bus.pad_a, m_pa);
        chk("tx_ready", bus.tx_ready, !rst && m_ready());
        chk("dir_out", bus.dir_out, mode == M_OUT || mode == M_DRV);
        chk("rx_valid", bus.rx_valid, m_valid);
        chk("rx_data", bus.rx_data, m_rx);
    endtask
    task automatic cycle(input bit v, input logic [W-1:0] d, input logic [W-1:0] y);
        bus.tx_valid = v;
        bus.tx_data  = d;
        bus.pad_y    = y;
        @(posedge clk);
        if (rst) m_reset(); else model_edge();
        #1;
        check_all();
        if (bus.rx_valid) pulses++;
    endtask
    initial begin
        logic [W-1:0] q[$];
        logic [W-1:0] y;
        m_reset();
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h55;
        bus.pad_y    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pad_en", bus.pad_en, 8'hFF);
        chk("rst_pad_a", bus.pad_a, 8'h00);
        chk("rst_tx_ready", bus.tx_ready, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        rst = 1'b0;
        cycle(1, 8'hA5, 8'h00);
        chk("single_pad_a", bus.pad_a, 8'hA5);
        repeat (7) cycle(0, 8'h00, 8'h00);
        q = '{8'h01, 8'h02, 8'h03};
        repeat (12) begin
            cycle(q.size() > 0, q.size() > 0 ? q[0] : 8'h00, 8'h00);
            if (m_acc) void'(q.pop_front());
        end
        chk("b2b_last_word", bus.pad_a, 8'h03);
        pulses = 0;
        repeat (10) cycle(0, 8'h00, 8'h3C);
        chk("rx_pulses", pulses, 1);
        chk("rx_word", bus.rx_data, 8'h3C);
        repeat (6) cycle(0, 8'h00, 8'h3C);
        chk("rx_no_repeat", pulses, 1);
        repeat (8) cycle(0, 8'h00, 8'h00);
        pulses = 0;
        repeat (3) cycle(0, 8'h00, 8'h3C);
        repeat (8) cycle(0, 8'h00, 8'h00);
        chk("glitch_drop", pulses, 0);
        chk("glitch_rx_data", bus.rx_data, 8'h00);
        pulses = 0;
        repeat (4) cycle(0, 8'h00, 8'h3C);
        repeat (10) cycle(0, 8'h00, 8'h00);
        chk("glitch_keep", pulses, 2);
        pulses = 0;
        cycle(1, 8'h5A, 8'hAA);
        for (int i = 0; i < 20 && mode != M_RX; i++) cycle(0, 8'h00, i[0] ? 8'hAA : 8'h55);
        chk("echo_quiet", pulses, 0);
        repeat (8) cycle(0, 8'h00, 8'h77);
        chk("echo_return_pulse", pulses, 1);
        chk("echo_return_word", bus.rx_data, 8'h77);
        cycle(1, 8'hC3, 8'h77);
        for (int i = 0; i < 10 && mode != M_DRV; i++) cycle(0, 8'h00, 8'h77);
        chk("reach_drive", bus.pad_en, 8'h00);
        #3;
        rst = 1'b1;
        m_reset();
        #1;
        chk("async_pad_en", bus.pad_en, 8'hFF);
        chk("async_tx_ready", bus.tx_ready, 0);
        cycle(0, 8'h00, 8'h00);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", bus.tx_ready, 1);
        chk("post_rst_dir", bus.dir_out, 0);
        y = '0;
        repeat (800) begin
            if ($urandom_range(0, 5) == 0) y = W'($urandom);
            cycle(1'($urandom_range(0, 1)), W'($urandom), y);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
